// File: rtl/id_ex_operand_stage.sv
// Operand-read / ID-EX register stage: RAW hazard detection, EX/MEM/WB bypass or interlock.
// Build option: define OPERAND_FORWARD_EN for bypass muxes; otherwise every RAW hazard interlocks.
module id_ex_operand_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_we,
  input  logic [1:0]       id_wd_sel,
  input  logic [31:0]      id_imm,
  input  logic [31:0]      id_pc4,
  input  logic             flush,
  output logic [4:0]       rf_rR1,
  output logic [4:0]       rf_rR2,
  input  logic [31:0]      rf_rD1,
  input  logic [31:0]      rf_rD2,
  input  logic [31:0]      ex_alu_result,
  input  logic [4:0]       mem_rd,
  input  logic             mem_we,
  input  logic [31:0]      mem_wD,
  input  logic [4:0]       wb_rd,
  input  logic             wb_we,
  input  logic [31:0]      wb_wD,
  output logic             id_stall,
  output logic             ex_valid,
  output logic [31:0]      ex_op1,
  output logic [31:0]      ex_op2,
  output logic [4:0]       ex_rd,
  output logic             ex_we,
  output logic [1:0]       ex_wd_sel,
  output logic [31:0]      ex_imm,
  output logic [31:0]      ex_pc4,
  output logic [CNT_W-1:0] hazard_cnt
);
  localparam int DATA_W = 32;

  function automatic logic src_hit(input logic vld, input logic used, input logic [4:0] rs,
                                   input logic we, input logic [4:0] rd);
    return vld && used && (rs != 5'd0) && we && (rd == rs);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic ex_live;
  logic ex_hit1, mem_hit1, wb_hit1;
  logic ex_hit2, mem_hit2, wb_hit2;
  logic stall_raw, bubble;
  logic [DATA_W-1:0] op1, op2;

  assign rf_rR1  = id_rs1;
  assign rf_rR2  = id_rs2;
  assign ex_live = ex_valid & ex_we;

  assign ex_hit1  = src_hit(id_valid, id_use_rs1, id_rs1, ex_live, ex_rd);
  assign mem_hit1 = src_hit(id_valid, id_use_rs1, id_rs1, mem_we,  mem_rd);
  assign wb_hit1  = src_hit(id_valid, id_use_rs1, id_rs1, wb_we,   wb_rd);
  assign ex_hit2  = src_hit(id_valid, id_use_rs2, id_rs2, ex_live, ex_rd);
  assign mem_hit2 = src_hit(id_valid, id_use_rs2, id_rs2, mem_we,  mem_rd);
  assign wb_hit2  = src_hit(id_valid, id_use_rs2, id_rs2, wb_we,   wb_rd);

`ifdef OPERAND_FORWARD_EN
  logic [DATA_W-1:0] ex_fwd;

  function automatic logic [DATA_W-1:0] pick(input logic [4:0] rs, input logic exh, input logic memh,
                                             input logic wbh, input logic [DATA_W-1:0] fwd,
                                             input logic [DATA_W-1:0] mem_v, input logic [DATA_W-1:0] wb_v,
                                             input logic [DATA_W-1:0] rf_v);
    if (rs == 5'd0) return '0;
    if (exh)        return fwd;
    if (memh)       return mem_v;
    if (wbh)        return wb_v;
    return rf_v;
  endfunction

  // Load data (sel 01) does not exist yet in EX; that case is covered by the load-use stall.
  always_comb begin
    case (ex_wd_sel)
      2'b10:   ex_fwd = ex_imm;
      2'b11:   ex_fwd = ex_pc4;
      default: ex_fwd = ex_alu_result;
    endcase
  end

  assign op1 = pick(id_rs1, ex_hit1, mem_hit1, wb_hit1, ex_fwd, mem_wD, wb_wD, rf_rD1);
  assign op2 = pick(id_rs2, ex_hit2, mem_hit2, wb_hit2, ex_fwd, mem_wD, wb_wD, rf_rD2);
  assign stall_raw = (ex_hit1 | ex_hit2) & (ex_wd_sel == 2'b01);
`else
  logic unused_bypass;
  assign unused_bypass = ^{ex_alu_result, mem_wD, wb_wD};

  assign op1 = rf_rD1;
  assign op2 = rf_rD2;
  assign stall_raw = ex_hit1 | mem_hit1 | wb_hit1 | ex_hit2 | mem_hit2 | wb_hit2;
`endif

  assign id_stall = stall_raw & ~flush;
  assign bubble   = flush | stall_raw;

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_op1     <= '0;
      ex_op2     <= '0;
      ex_rd      <= '0;
      ex_we      <= 1'b0;
      ex_wd_sel  <= '0;
      ex_imm     <= '0;
      ex_pc4     <= '0;
      hazard_cnt <= '0;
    end else begin
      if (bubble) begin
        ex_valid  <= 1'b0;
        ex_op1    <= '0;
        ex_op2    <= '0;
        ex_rd     <= '0;
        ex_we     <= 1'b0;
        ex_wd_sel <= '0;
        ex_imm    <= '0;
        ex_pc4    <= '0;
      end else begin
        ex_valid  <= id_valid;
        ex_op1    <= op1;
        ex_op2    <= op2;
        ex_rd     <= id_rd;
        ex_we     <= id_we & id_valid & (id_rd != 5'd0);
        ex_wd_sel <= id_wd_sel;
        ex_imm    <= id_imm;
        ex_pc4    <= id_pc4;
      end
      if (id_stall) hazard_cnt <= sat_inc(hazard_cnt);
    end
  end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed hazard scenarios plus randomized cycles
// checked against a producer-list reference model; follows OPERAND_FORWARD_EN like the DUT.
module tb_id_ex_operand_stage;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_use_rs1, id_use_rs2, id_we, flush, mem_we, wb_we;
  logic [4:0] id_rs1, id_rs2, id_rd, mem_rd, wb_rd, rf_rR1, rf_rR2, ex_rd;
  logic [1:0] id_wd_sel, ex_wd_sel;
  logic [31:0] id_imm, id_pc4, rf_rD1, rf_rD2, ex_alu_result, mem_wD, wb_wD;
  logic id_stall, ex_valid, ex_we;
  logic [31:0] ex_op1, ex_op2, ex_imm, ex_pc4;
  logic [CW-1:0] hazard_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model of the ID/EX register contents
  bit          m_valid, m_we;
  logic [4:0]  m_rd;
  logic [1:0]  m_sel;
  logic [31:0] m_op1, m_op2, m_imm, m_pc4;
  int          m_cnt;

  typedef struct { bit live; logic [4:0] rd; logic [31:0] val; } prod_t;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_wd_sel(id_wd_sel), .id_imm(id_imm), .id_pc4(id_pc4), .flush(flush),
    .rf_rR1(rf_rR1), .rf_rR2(rf_rR2), .rf_rD1(rf_rD1), .rf_rD2(rf_rD2),
    .ex_alu_result(ex_alu_result), .mem_rd(mem_rd), .mem_we(mem_we), .mem_wD(mem_wD),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_wD(wb_wD), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd), .ex_we(ex_we), .ex_wd_sel(ex_wd_sel),
    .ex_imm(ex_imm), .ex_pc4(ex_pc4), .hazard_cnt(hazard_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void producers(output prod_t p[3]);
    logic [31:0] exv;
    exv = (m_sel == 2'd2) ? m_imm : (m_sel == 2'd3) ? m_pc4 : ex_alu_result;
    p[0] = '{live: m_valid && m_we, rd: m_rd, val: exv};
    p[1] = '{live: mem_we, rd: mem_rd, val: mem_wD};
    p[2] = '{live: wb_we, rd: wb_rd, val: wb_wD};
  endfunction

  // index of the youngest in-flight writer of rs, or -1
  function automatic int first_hit(input logic [4:0] rs, input bit used);
    prod_t p[3];
    producers(p);
    if (!(id_valid && used && rs != 0)) return -1;
    for (int i = 0; i < 3; i++) if (p[i].live && p[i].rd == rs) return i;
    return -1;
  endfunction

  function automatic bit ref_stall();
    int h1, h2;
    h1 = first_hit(id_rs1, id_use_rs1);
    h2 = first_hit(id_rs2, id_use_rs2);
    if (flush) return 0;
`ifdef OPERAND_FORWARD_EN
    return ((h1 == 0) || (h2 == 0)) && m_sel == 2'd1;
`else
    return (h1 >= 0) || (h2 >= 0);
`endif
  endfunction

  function automatic logic [31:0] ref_op(input logic [4:0] rs, input bit used, input logic [31:0] rf);
`ifdef OPERAND_FORWARD_EN
    prod_t p[3];
    int h;
    producers(p);
    h = first_hit(rs, used);
    if (rs == 0) return 32'd0;
    return (h >= 0) ? p[h].val : rf;
`else
    return rf;
`endif
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_rd = 0; m_sel = 0;
    m_op1 = 0; m_op2 = 0; m_imm = 0; m_pc4 = 0; m_cnt = 0;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_we = 0; id_wd_sel = 0; id_imm = 0; id_pc4 = 0; flush = 0;
    rf_rD1 = 0; rf_rD2 = 0; ex_alu_result = 0;
    mem_rd = 0; mem_we = 0; mem_wD = 0; wb_rd = 0; wb_we = 0; wb_wD = 0;
  endtask

  task automatic check_ex(input string tag);
    chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, ".ex_op1"}, ex_op1, m_op1);
    chk({tag, ".ex_op2"}, ex_op2, m_op2);
    chk({tag, ".ex_rd"}, 32'(ex_rd), 32'(m_rd));
    chk({tag, ".ex_we"}, 32'(ex_we), 32'(m_we));
    chk({tag, ".ex_wd_sel"}, 32'(ex_wd_sel), 32'(m_sel));
    chk({tag, ".ex_imm"}, ex_imm, m_imm);
    chk({tag, ".ex_pc4"}, ex_pc4, m_pc4);
    chk({tag, ".hazard_cnt"}, 32'(hazard_cnt), 32'(m_cnt));
  endtask

  // one clock: check combinational outputs, advance the model, check the registered outputs
  task automatic cycle(input string tag);
    bit st;
    logic [31:0] n1, n2;
    #1;
    st = ref_stall();
    n1 = ref_op(id_rs1, id_use_rs1, rf_rD1);
    n2 = ref_op(id_rs2, id_use_rs2, rf_rD2);
    chk({tag, ".rf_rR1"}, 32'(rf_rR1), 32'(id_rs1));
    chk({tag, ".rf_rR2"}, 32'(rf_rR2), 32'(id_rs2));
    chk({tag, ".id_stall"}, 32'(id_stall), 32'(st));
    @(posedge clk);
    #1;
    if (st && m_cnt < MAX) m_cnt++;
    if (flush || st) begin
      m_valid = 0; m_we = 0; m_rd = 0; m_sel = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_pc4 = 0;
    end else begin
      m_valid = id_valid; m_op1 = n1; m_op2 = n2; m_rd = id_rd;
      m_we = id_we && id_valid && id_rd != 0; m_sel = id_wd_sel; m_imm = id_imm; m_pc4 = id_pc4;
    end
    check_ex(tag);
  endtask

  task automatic load_into_ex(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] imm);
    idle();
    id_valid = 1; id_rd = rd; id_we = 1; id_wd_sel = sel; id_imm = imm; id_pc4 = 32'h100;
    cycle("load_ex");
  endtask

  int c0;

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_ex("reset");
    rst_n = 1;

    // reset asserted in the middle of a load-use stall
    load_into_ex(5'd7, 2'd1, 32'h0);
    idle(); id_valid = 1; id_rs1 = 7; id_use_rs1 = 1;
    #1;
    chk("midstall.id_stall_before", 32'(id_stall), 32'd1);
    rst_n = 0;
    #1;
    model_reset();
    check_ex("midstall_reset");
    chk("midstall.id_stall_after", 32'(id_stall), 32'(ref_stall()));
    #1;
    rst_n = 1;

    // load-use: one stall, then MEM forward
    load_into_ex(5'd7, 2'd1, 32'h0);
    idle(); id_valid = 1; id_rs1 = 7; id_use_rs1 = 1; rf_rD1 = 32'h1111;
    cycle("loaduse.stall");
    mem_rd = 7; mem_we = 1; mem_wD = 32'hDEADBEEF;
    cycle("loaduse.mem_fwd");
`ifdef OPERAND_FORWARD_EN
    chk("loaduse.op1_const", ex_op1, 32'hDEADBEEF);
    chk("loaduse.cnt_const", 32'(hazard_cnt), 32'd1);
`endif

    // flush in the load-use cycle
    load_into_ex(5'd7, 2'd1, 32'h0);
    c0 = m_cnt;
    idle(); id_valid = 1; id_rs1 = 7; id_use_rs1 = 1; flush = 1;
    cycle("flush_lu");
    chk("flush_lu.cnt_unchanged", 32'(hazard_cnt), 32'(c0));

    // EX forward of an ALU result
    load_into_ex(5'd5, 2'd0, 32'h0);
    idle(); id_valid = 1; id_rs1 = 5; id_use_rs1 = 1; ex_alu_result = 32'h1234; rf_rD1 = 32'h5555;
    cycle("ex_fwd");
`ifdef OPERAND_FORWARD_EN
    chk("ex_fwd.op1_const", ex_op1, 32'h1234);
`endif

    // EX > MEM > WB priority, then x0 with every stage matching
    load_into_ex(5'd5, 2'd0, 32'h0);
    idle(); id_valid = 1; id_rs2 = 5; id_use_rs2 = 1; ex_alu_result = 32'hA;
    mem_rd = 5; mem_we = 1; mem_wD = 32'hB; wb_rd = 5; wb_we = 1; wb_wD = 32'hC; rf_rD2 = 32'hD;
    cycle("prio");
`ifdef OPERAND_FORWARD_EN
    chk("prio.op2_const", ex_op2, 32'hA);
`endif
    load_into_ex(5'd0, 2'd0, 32'h0);
    idle(); id_valid = 1; id_rs2 = 0; id_use_rs2 = 1; ex_alu_result = 32'hA;
    mem_rd = 0; mem_we = 1; mem_wD = 32'hB; wb_rd = 0; wb_we = 1; wb_wD = 32'hC; rf_rD2 = 32'h0;
    cycle("prio_x0");
    chk("prio_x0.op2_const", ex_op2, 32'h0);

    // dependent add after add walking through EX, MEM, WB
    load_into_ex(5'd5, 2'd0, 32'h0);
    c0 = m_cnt;
    idle(); id_valid = 1; id_rs1 = 5; id_use_rs1 = 1; ex_alu_result = 32'h77; rf_rD1 = 32'h0BAD;
    cycle("dep.ex");
    mem_rd = 5; mem_we = 1; mem_wD = 32'h77;
    cycle("dep.mem");
    mem_we = 0; wb_rd = 5; wb_we = 1; wb_wD = 32'h77;
    cycle("dep.wb");
    wb_we = 0; rf_rD1 = 32'h77;
    cycle("dep.commit");
`ifndef OPERAND_FORWARD_EN
    chk("dep.stall_cycles", 32'(hazard_cnt), 32'(c0 + 3));
    chk("dep.op1_rf", ex_op1, 32'h77);
`endif

    // drive the counter into saturation
    for (int i = 0; i < 20; i++) begin
      load_into_ex(5'd9, 2'd1, 32'h0);
      idle(); id_valid = 1; id_rs2 = 9; id_use_rs2 = 1;
      cycle("sat");
    end
    chk("sat.cnt_const", 32'(hazard_cnt), 32'(MAX));

    // randomized cycles
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      id_rd = 5'($urandom_range(0, 3)); id_we = 1'($urandom); id_wd_sel = 2'($urandom);
      id_imm = $urandom; id_pc4 = $urandom; flush = ($urandom_range(0, 7) == 0);
      rf_rD1 = $urandom; rf_rD2 = $urandom; ex_alu_result = $urandom;
      mem_rd = 5'($urandom_range(0, 3)); mem_we = 1'($urandom); mem_wD = $urandom;
      wb_rd = 5'($urandom_range(0, 3)); wb_we = 1'($urandom); wb_wD = $urandom;
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
